// File: rtl/mult_control_unit.sv
// Moore sequencer for a shift-add multiplier datapath with a start/busy/done handshake.
// Optional early termination on B==0 is enabled by defining MULT_EARLY_TERM_EN.
module mult_control_unit #(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic zero,
    input  logic lsb_b,
    output logic en_a,
    output logic ld_shift_a,
    output logic en_b,
    output logic ld_shift_b,
    output logic en_p,
    output logic ld_add_p,
    output logic busy,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        TEST   = 3'd3,
        ADD    = 3'd4,
        SHIFT  = 3'd5,
        DONE   = 3'd6
    } state_e;

    typedef struct packed {
        logic en_a;
        logic ld_shift_a;
        logic en_b;
        logic ld_shift_b;
        logic en_p;
        logic ld_add_p;
        logic busy;
        logic done;
    } ctrl_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;

`ifndef MULT_EARLY_TERM_EN
    logic unused_zero;
    assign unused_zero = zero;
`endif

    // Next state and counter; outputs are decoded from the next state and registered
    // so that they always reflect the state register with no input-to-output path.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: state_d = TEST;
            TEST: begin
`ifdef MULT_EARLY_TERM_EN
                if (zero) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(N)) begin
                    state_d = DONE;
                end else if (lsb_b) begin
                    state_d = ADD;
                end else begin
                    state_d = SHIFT;
                end
`else
                if (cnt_q == CNT_W'(N)) begin
                    state_d = DONE;
                end else if (lsb_b) begin
                    state_d = ADD;
                end else begin
                    state_d = SHIFT;
                end
`endif
            end
            ADD:   state_d = SHIFT;
            SHIFT: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = SETTLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            LOAD: begin
                ctrl_d.en_a = 1'b1;
                ctrl_d.en_b = 1'b1;
                ctrl_d.en_p = 1'b1;
                ctrl_d.busy = 1'b1;
            end
            SETTLE, TEST: ctrl_d.busy = 1'b1;
            ADD: begin
                ctrl_d.en_p     = 1'b1;
                ctrl_d.ld_add_p = 1'b1;
                ctrl_d.busy     = 1'b1;
            end
            SHIFT: begin
                ctrl_d.en_a       = 1'b1;
                ctrl_d.ld_shift_a = 1'b1;
                ctrl_d.en_b       = 1'b1;
                ctrl_d.ld_shift_b = 1'b1;
                ctrl_d.busy       = 1'b1;
            end
            DONE: begin
                ctrl_d.busy = 1'b1;
                ctrl_d.done = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign en_a       = ctrl_q.en_a;
    assign ld_shift_a = ctrl_q.ld_shift_a;
    assign en_b       = ctrl_q.en_b;
    assign ld_shift_b = ctrl_q.ld_shift_b;
    assign en_p       = ctrl_q.en_p;
    assign ld_add_p   = ctrl_q.ld_add_p;
    assign busy       = ctrl_q.busy;
    assign done       = ctrl_q.done;

endmodule

// File: tb/tb_mult_control_unit.sv
// Bench for mult_control_unit: behavioural datapath, trace-level reference model, directed and random runs.
`timescale 1ns/1ps
module tb_mult_control_unit;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 2 * N;

    // Output vector order: {en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done}
    localparam logic [7:0] V_IDLE  = 8'b0000_0000;
    localparam logic [7:0] V_LOAD  = 8'b1010_1010;
    localparam logic [7:0] V_WAIT  = 8'b0000_0010;
    localparam logic [7:0] V_ADD   = 8'b0000_1110;
    localparam logic [7:0] V_SHIFT = 8'b1111_0010;
    localparam logic [7:0] V_DONE  = 8'b0000_0011;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic start = 1'b0;
    logic zero_f = 1'b0;
    logic lsb_f = 1'b0;
    logic en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done;

    logic [N-1:0]  a_in = '0;
    logic [N-1:0]  b_in = '0;
    logic [N-1:0]  b_reg = '0;
    logic [PW-1:0] a_reg = '0;
    logic [PW-1:0] p_reg = '0;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [7:0]    exp_q[$];
    logic [PW-1:0] exp_prod = '0;
    logic [7:0]    cmp_exp;
    logic [7:0]    dut_vec;

    assign dut_vec = {en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done};

    always #5 clk = ~clk;

    mult_control_unit #(.N(N)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .zero       (zero_f),
        .lsb_b      (lsb_f),
        .en_a       (en_a),
        .ld_shift_a (ld_shift_a),
        .en_b       (en_b),
        .ld_shift_b (ld_shift_b),
        .en_p       (en_p),
        .ld_add_p   (ld_add_p),
        .busy       (busy),
        .done       (done)
    );

    // Datapath the sequencer drives; flags are registered copies of B, one cycle late.
    always @(posedge clk) begin
        zero_f <= (b_reg == '0);
        lsb_f  <= b_reg[0];
        if (en_a) a_reg <= ld_shift_a ? (a_reg << 1) : {{N{1'b0}}, a_in};
        if (en_b) b_reg <= ld_shift_b ? (b_reg >> 1) : b_in;
        if (en_p) p_reg <= ld_add_p ? (p_reg + a_reg) : '0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-operation output trace derived from the multiplier operand.
    task automatic push_trace(input logic [N-1:0] b);
        int k;
        k = N;
`ifdef MULT_EARLY_TERM_EN
        k = 0;
        for (int i = 0; i < N; i++) if (b[i]) k = i + 1;
`endif
        exp_q.push_back(V_LOAD);
        exp_q.push_back(V_WAIT);
        for (int i = 0; i < k; i++) begin
            exp_q.push_back(V_WAIT);
            if (b[i]) exp_q.push_back(V_ADD);
            exp_q.push_back(V_SHIFT);
            exp_q.push_back(V_WAIT);
        end
        exp_q.push_back(V_WAIT);
        exp_q.push_back(V_DONE);
    endtask

    // Reference model: idle when the trace queue is empty, accepts start only then.
    always @(posedge clk) begin
        if (clr) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (start) begin
            push_trace(b_in);
            exp_prod = PW'(a_in) * PW'(b_in);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_exp = (exp_q.size() != 0) ? exp_q[0] : V_IDLE;
            check("outputs", int'(dut_vec), int'(cmp_exp));
            if (cmp_exp == V_DONE) check("product", int'(p_reg), int'(exp_prod));
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle", int'(ok), 1);
    endtask

    task automatic run_directed(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                                input int exp_done, input int exp_adds, input int exp_shifts);
        int adds, shifts, done_cyc, done_cnt;
        adds = 0; shifts = 0; done_cyc = -1; done_cnt = 0;
        a_in = a;
        b_in = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (en_p && ld_add_p) adds++;
            if (en_a && ld_shift_a) shifts++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        check({name, "_done_cycle"}, done_cyc, exp_done);
        check({name, "_done_width"}, done_cnt, 1);
        check({name, "_adds"}, adds, exp_adds);
        check({name, "_shifts"}, shifts, exp_shifts);
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d;
        // Reset held with start asserted: everything stays at zero.
        clr = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_outputs", int'(dut_vec), int'(V_IDLE));
        end
        clr = 1'b0;
        start = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        run_directed("all_ones", 4'd3, 4'b1111, 20, 4, 4);
`ifdef MULT_EARLY_TERM_EN
        run_directed("b_zero", 4'd9, 4'b0000, 4, 0, 0);
        run_directed("b_0010", 4'd7, 4'b0010, 11, 1, 2);
        d = 11;
`else
        run_directed("b_zero", 4'd9, 4'b0000, 16, 0, 4);
        run_directed("b_0010", 4'd7, 4'b0010, 17, 1, 4);
        d = 17;
`endif

        // Reset during the ADD of the second iteration.
        a_in = 4'd5;
        b_in = 4'b1111;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        check("clr_in_add", int'(dut_vec), int'(V_ADD));
        clr = 1'b1;
        @(negedge clk);
        check("clr_to_idle", int'(dut_vec), int'(V_IDLE));
        clr = 1'b0;
        run_directed("after_clr", 4'd15, 4'b1111, 20, 4, 4);

        // start held high: one IDLE cycle between DONE and the next LOAD.
        a_in = 4'd6;
        b_in = 4'b0010;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= d + 2; c++) begin
            @(negedge clk);
            if (c == d)     check("held_done", int'(dut_vec), int'(V_DONE));
            if (c == d + 1) check("held_idle_gap", int'(dut_vec), int'(V_IDLE));
            if (c == d + 2) check("held_reload", int'(dut_vec), int'(V_LOAD));
        end
        start = 1'b0;
        wait_idle();

        // Random operands, random start pulses while busy, occasional reset.
        for (int op = 0; op < 60; op++) begin
            int  gap;
            bit  started;
            bit  ok;
            a_in = N'($urandom);
            b_in = N'($urandom);
            gap = $urandom_range(0, 2);
            start = 1'b0;
            repeat (gap) @(negedge clk);
            start = 1'b1;
            started = 1'b0;
            ok = 1'b0;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                if (clr) clr = 1'b0;
                if (exp_q.size() != 0) begin
                    started = 1'b1;
                end else if (started) begin
                    ok = 1'b1;
                    break;
                end
                if (started) begin
                    start = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 31) == 0) clr = 1'b1;
                end
            end
            check("random_op_completes", int'(ok), 1);
        end
        start = 1'b0;
        clr = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
